// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Holds the full-adder equations, the overflow rule and the
// elaboration-time parameter check.

`ifndef ADD_SUB_PKG_SV
`define ADD_SUB_PKG_SV

// Elaboration guard: the operand must split into STAGES equal slices.
`define ADD_SUB_CHECK_PARAMS(W, S) \
    if ((S) < 1) begin : g_bad_stages \
        $error("add_sub_pipe: STAGES must be at least 1"); \
    end else if (((W) % (S)) != 0) begin : g_bad_split \
        $error("add_sub_pipe: WIDTH must be a multiple of STAGES"); \
    end

package add_sub_pkg;

    // Per-stage control bits travelling alongside the datapath slices.
    typedef struct packed {
        logic valid;   // beat present in this stage
        logic carry;   // carry out of the slice added in this stage
        logic ovf;     // signed overflow, only meaningful in the last stage
    } stage_flags_t;

    // Sum bit of a single full-adder cell.
    function automatic logic fa_sum(input logic x, input logic y, input logic cin);
        return x ^ y ^ cin;
    endfunction

    // Carry bit of a single full-adder cell (majority of the three inputs).
    function automatic logic fa_carry(input logic x, input logic y, input logic cin);
        return (x & y) | (x & cin) | (y & cin);
    endfunction

    // Two's-complement overflow: carry into the MSB disagrees with carry out of it.
    function automatic logic ovf_calc(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

endpackage

`endif

// File: rtl/add_slice.sv
// Combinational SLICE-bit ripple-carry adder built from full-adder cells.
// Besides the carry out it exposes the carry into its top bit, which the
// last pipeline stage needs to derive signed overflow.

module add_slice
    import add_sub_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] sum,
    output logic             co,
    output logic             c_msb_in
);

    // carry_s[i] is the carry into bit i; carry_s[SLICE] leaves the slice.
    logic [SLICE:0] carry_s;

    assign carry_s[0] = ci;

    for (genvar i = 0; i < SLICE; i++) begin : g_cell
        assign sum[i]       = fa_sum(a[i], b[i], carry_s[i]);
        assign carry_s[i+1] = fa_carry(a[i], b[i], carry_s[i]);
    end

    assign co       = carry_s[SLICE];
    assign c_msb_in = carry_s[SLICE-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement adder/subtractor.
// The operands are cut into STAGES slices of SLICE bits; stage k adds slice k
// and hands its carry to stage k+1 through a register. Finished result bits
// are shifted in from the top of a "done" vector and the still-pending operand
// bits are shifted down, so every stage always works on bits [SLICE-1:0] of
// its pending operands. The whole pipe advances together and freezes while the
// output beat is held by downstream backpressure.

module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    `ADD_SUB_CHECK_PARAMS(WIDTH, STAGES)

    localparam int SLICE = WIDTH / STAGES;

    // Contents of one pipeline register.
    typedef struct packed {
        stage_flags_t     flags;
        logic [WIDTH-1:0] done;   // finished result bits, aligned to the top
        logic [WIDTH-1:0] pa;     // operand A bits not yet added, aligned to bit 0
        logic [WIDTH-1:0] pb;     // operand B bits (already inverted for sub), aligned to bit 0
    } stage_t;

    stage_t stage_q [STAGES];
    stage_t stage_d [STAGES];
    logic   adv_s;

    // The pipe moves whenever the output slot is empty or being taken.
    assign adv_s    = !stage_q[STAGES-1].flags.valid || out_ready;
    assign in_ready = adv_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           in_s;
        stage_t           d_s;
        logic [SLICE-1:0] slice_sum_s;
        logic             slice_co_s;
        logic             slice_cmsb_s;
        logic             unused_in_s;

        if (k == 0) begin : g_first
            // Stage 0 captures the operands; subtraction inverts b and the borrow-in here.
            always_comb begin
                in_s             = '0;
                in_s.flags.valid = in_valid;
                in_s.flags.carry = sub ^ ci;
                in_s.pa          = a;
                if (sub) begin
                    in_s.pb = ~b;
                end else begin
                    in_s.pb = b;
                end
            end
        end else begin : g_next
            // Later stages consume the register of the previous stage.
            always_comb begin
                in_s = stage_q[k-1];
            end
        end

        add_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .a        (in_s.pa[SLICE-1:0]),
            .b        (in_s.pb[SLICE-1:0]),
            .ci       (in_s.flags.carry),
            .sum      (slice_sum_s),
            .co       (slice_co_s),
            .c_msb_in (slice_cmsb_s)
        );

        // Next-state of this stage: add the low slice, shift result in and pending bits down.
        always_comb begin
            d_s             = '0;
            d_s.flags.valid = in_s.flags.valid;
            d_s.flags.carry = slice_co_s;
            d_s.flags.ovf   = (k == STAGES - 1) ? ovf_calc(slice_cmsb_s, slice_co_s) : 1'b0;
            d_s.done        = (in_s.done >> SLICE) | (WIDTH'(slice_sum_s) << (WIDTH - SLICE));
            d_s.pa          = in_s.pa >> SLICE;
            d_s.pb          = in_s.pb >> SLICE;
        end

        assign stage_d[k]  = d_s;
        // The incoming overflow flag is always recomputed, never forwarded.
        assign unused_in_s = in_s.flags.ovf;
    end

    // Pipeline registers: cleared by reset, advanced together, frozen on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[STAGES-1].flags.valid;
    assign sum       = stage_q[STAGES-1].done;
    assign co        = stage_q[STAGES-1].flags.carry;
    assign ovf       = stage_q[STAGES-1].flags.ovf;

    // After the last stage no operand bits remain pending.
    logic unused_q_s;
    assign unused_q_s = ^{stage_q[STAGES-1].pa, stage_q[STAGES-1].pb};

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: three configurations (16/4, 16/1, 8/2) run side by
// side, each with directed vectors, a back-to-back random stream, a random
// backpressure/gap phase and a mid-stream reset. Expected results come from
// plain integer arithmetic and are matched in order against accepted beats.

module tb_add_sub_pipe;

    typedef struct packed {
        logic [31:0] sum;
        logic        co;
        logic        ovf;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
    } exp_t;

    logic clk = 1'b0;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of a +/- b with carry/borrow over w bits, from integer arithmetic.
    function automatic res_t ref_op(input int w, input logic [31:0] a_v, input logic [31:0] b_v,
                                    input logic ci_v, input logic sub_v);
        res_t   r;
        longint modv, half, ua, ub, raw, sa, sb, sres, c;
        modv = longint'(1) << w;
        half = modv / 2;
        ua   = longint'(a_v) % modv;
        ub   = longint'(b_v) % modv;
        c    = longint'(ci_v);
        if (sub_v) raw = ua + (modv - 1 - ub) + (1 - c);
        else       raw = ua + ub + c;
        r.sum = 32'(raw % modv);
        r.co  = (raw >= modv);
        sa    = (ua >= half) ? ua - modv : ua;
        sb    = (ub >= half) ? ub - modv : ub;
        sres  = sub_v ? (sa - sb - c) : (sa + sb + c);
        r.ovf = (sres < -half) || (sres >= half);
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W = (g == 2) ? 8 : 16;
        localparam int S = (g == 0) ? 4 : ((g == 1) ? 1 : 2);

        logic         rst = 1'b1;
        logic         in_valid = 1'b0;
        logic         in_ready;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic         ci = 1'b0;
        logic         sub = 1'b0;
        logic         out_valid;
        logic         out_ready = 1'b1;
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;

        exp_t         exp_q[$];
        int           cyc = 0;
        int           last_stall = -1;
        logic         held_valid = 1'b0;
        logic [W-1:0] held_sum = '0;
        logic         held_co = 1'b0;
        logic         held_ovf = 1'b0;

        add_sub_pipe #(
            .WIDTH  (W),
            .STAGES (S)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .ci        (ci),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .co        (co),
            .ovf       (ovf)
        );

        function automatic string nm(input string s);
            return $sformatf("cfg%0d_%s", g, s);
        endfunction

        // Present one beat and hold it until the DUT accepts it.
        task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic civ, input logic subv);
            logic acc;
            int   tries;
            acc   = 1'b0;
            tries = 0;
            in_valid = 1'b1; a = av; b = bv; ci = civ; sub = subv;
            while (!acc && tries < 50) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                tries++;
            end
            if (!acc) check(nm("send_timeout"), 32'd0, 32'd1);
            in_valid = 1'b0;
        endtask

        // Monitor: scoreboard, stall stability and handshake checks at mid-cycle.
        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (rst) begin
                    check(nm("rst_out_valid"), 32'(out_valid), 32'd0);
                    check(nm("rst_in_ready"), 32'(in_ready), 32'd1);
                    check(nm("rst_result"), 32'({sum, co, ovf}), 32'd0);
                    held_valid = 1'b0;
                end else begin
                    check(nm("no_x"), 32'($isunknown({out_valid, in_ready, sum, co, ovf})), 32'd0);
                    check(nm("in_ready"), 32'(in_ready), 32'(!(out_valid && !out_ready)));
                    if (held_valid) begin
                        check(nm("stall_valid"), 32'(out_valid), 32'd1);
                        check(nm("stall_result"), 32'({sum, co, ovf}), 32'({held_sum, held_co, held_ovf}));
                    end
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check(nm("unexpected_output"), 32'(sum), 32'hDEAD_BEEF);
                        end else begin
                            e = exp_q.pop_front();
                            check(nm("sum"), 32'(sum), e.r.sum);
                            check(nm("co"), 32'(co), 32'(e.r.co));
                            check(nm("ovf"), 32'(ovf), 32'(e.r.ovf));
                            if (e.cyc > last_stall) check(nm("latency"), 32'(cyc - e.cyc), 32'(S));
                            else check(nm("latency_min"), 32'((cyc - e.cyc) >= S), 32'd1);
                        end
                    end
                    if (out_valid && !out_ready) begin
                        last_stall = cyc;
                        held_valid = 1'b1;
                        held_sum = sum; held_co = co; held_ovf = ovf;
                    end else begin
                        held_valid = 1'b0;
                    end
                    if (in_valid && in_ready) begin
                        e.r   = ref_op(W, 32'(a), 32'(b), ci, sub);
                        e.cyc = cyc;
                        exp_q.push_back(e);
                    end
                end
                cyc++;
            end
        end

        // Driver: directed, streaming, random handshake, mid-stream reset, drain.
        initial begin
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;

            send(W'(16'hFFFF), W'(16'h0001), 1'b0, 1'b0);
            send(W'(16'h7FFF), W'(16'h0000), 1'b1, 1'b0);
            send(W'(16'h8000), W'(16'h0001), 1'b0, 1'b1);
            send(W'(16'h0005), W'(16'h0007), 1'b0, 1'b1);
            send(W'(16'h0005), W'(16'h0005), 1'b1, 1'b1);
            repeat (S + 2) begin @(posedge clk); #1; end

            for (int i = 0; i < 100; i++)
                send(W'($urandom()), W'($urandom()), 1'($urandom()), 1'($urandom()));

            for (int i = 0; i < 400; i++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = 1'($urandom());
                a   = W'($urandom());
                b   = W'($urandom());
                ci  = 1'($urandom());
                sub = 1'($urandom());
                @(posedge clk);
                #1;
            end

            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (S + 3) begin @(posedge clk); #1; end
            for (int i = 0; i < 3; i++)
                send(W'($urandom()), W'($urandom()), 1'($urandom()), 1'($urandom()));
            rst = 1'b1;
            exp_q.delete();
            #1;
            check(nm("async_rst_out_valid"), 32'(out_valid), 32'd0);
            check(nm("async_rst_in_ready"), 32'(in_ready), 32'd1);
            check(nm("async_rst_result"), 32'({sum, co, ovf}), 32'd0);
            @(posedge clk);
            #1 rst = 1'b0;
            send(W'(16'h1234), W'(16'h4321), 1'b1, 1'b0);

            for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
                @(posedge clk);
                #1;
            end
            check(nm("drain_empty"), 32'(exp_q.size()), 32'd0);
            repeat (S + 3) begin @(posedge clk); #1; end
            n_done++;
        end
    end

    // Pin the reference model against hand-computed results, then wait for all configs.
    initial begin
        int          pw  [7] = '{16, 16, 16, 16, 16, 8, 8};
        logic [31:0] pa  [7] = '{32'hFFFF, 32'h7FFF, 32'h8000, 32'h0005, 32'h0005, 32'h7F, 32'h80};
        logic [31:0] pb  [7] = '{32'h0001, 32'h0000, 32'h0001, 32'h0007, 32'h0005, 32'h01, 32'h80};
        logic        pci [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        psb [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] es  [7] = '{32'h0000, 32'h8000, 32'h7FFF, 32'hFFFE, 32'hFFFF, 32'h80, 32'h00};
        logic        ec  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        eo  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        res_t        rr;
        for (int i = 0; i < 7; i++) begin
            rr = ref_op(pw[i], pa[i], pb[i], pci[i], psb[i]);
            check($sformatf("model%0d_sum", i), rr.sum, es[i]);
            check($sformatf("model%0d_co", i), 32'(rr.co), 32'(ec[i]));
            check($sformatf("model%0d_ovf", i), 32'(rr.ovf), 32'(eo[i]));
        end

        for (int i = 0; i < 30000 && n_done < 3; i++) @(posedge clk);
        if (n_done < 3) begin
            n_vec++;
            n_fail++;
            $display("FAIL timeout: configs finished %0d expected 3", n_done);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
